// File: rtl/syn_fgyrus_pcm_loader.sv
// PCM-to-FFT-cache loader: reads one N-sample frame per enabled channel,
// applies the window coefficient (or bypasses it) and writes complex words
// into the FFT cache at bit-reversed addresses.
module syn_fgyrus_pcm_loader #(
  parameter int NUM_CHNNLS = 2,
  parameter int FFT_ADDR_W = 7,
  parameter int PCM_W      = 16,
  parameter int WIN_W      = 16,
  localparam int CH_W      = (NUM_CHNNLS > 1) ? $clog2(NUM_CHNNLS) : 1
) (
  input  logic                        clk_ir,
  input  logic                        rst_il,
  input  logic                        pcm_rdy_ih,
  input  logic                        abort_ih,
  input  logic [NUM_CHNNLS-1:0]       cfg_chnnl_en_id,
  input  logic                        cfg_win_bypass_ih,
  output logic                        pcm_rd_en_oh,
  output logic [FFT_ADDR_W-1:0]       pcm_rd_addr_od,
  input  logic [NUM_CHNNLS*PCM_W-1:0] pcm_rdata_id,
  output logic                        win_rd_en_oh,
  output logic [FFT_ADDR_W-1:0]       win_rd_addr_od,
  input  logic [WIN_W-1:0]            win_rdata_id,
  output logic                        cache_wr_en_oh,
  output logic [CH_W+FFT_ADDR_W-1:0]  cache_wr_addr_od,
  output logic [2*PCM_W-1:0]          cache_wr_data_od,
  output logic                        busy_oh,
  output logic                        done_oh,
  output logic                        overrun_oh
);

  localparam int P_W = PCM_W + WIN_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t                  state_q;
  logic [NUM_CHNNLS-1:0]   en_q;
  logic                    byp_q;
  logic                    rd_en_q;
  logic [FFT_ADDR_W-1:0]   rd_addr_q;
  logic [CH_W-1:0]         rd_ch_q;
  logic                    busy_q, done_q, ovr_q;

  logic                    s1_v_q, s2_v_q;
  logic [CH_W-1:0]         s1_ch_q, s2_ch_q;
  logic [FFT_ADDR_W-1:0]   s1_rev_q, s2_rev_q;
  logic signed [P_W-1:0]   s2_prod_q;
  logic                    wr_en_q;
  logic [CH_W+FFT_ADDR_W-1:0] wr_addr_q;
  logic [2*PCM_W-1:0]      wr_data_q;

  logic                    first_found, next_found;
  logic [CH_W-1:0]         first_ch, next_ch;
  logic signed [PCM_W-1:0] sample_sel;
  logic signed [P_W-1:0]   samp_ext, coef_ext, prod_d, rnd;
  logic [PCM_W-1:0]        result_d;

  function automatic logic [FFT_ADDR_W-1:0] bitrev(input logic [FFT_ADDR_W-1:0] x);
    logic [FFT_ADDR_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < FFT_ADDR_W; b++) r[b] = x[FFT_ADDR_W-1-b];
    return r;
  endfunction

  // Lowest enabled channel at start, and next enabled channel above the current one.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    next_found  = 1'b0;
    next_ch     = '0;
    for (int unsigned c = 0; c < NUM_CHNNLS; c++) begin
      if (cfg_chnnl_en_id[c] && !first_found) begin
        first_found = 1'b1;
        first_ch    = CH_W'(c);
      end
      if (en_q[c] && (c > int'(rd_ch_q)) && !next_found) begin
        next_found = 1'b1;
        next_ch    = CH_W'(c);
      end
    end
  end

  // Sample select, multiply, and round-half-up rescale.
  // Bypass pre-scales the sample by 2^WIN_W so the shared rounding path returns it unchanged.
  always_comb begin
    sample_sel = '0;
    for (int unsigned c = 0; c < NUM_CHNNLS; c++) begin
      if (s1_ch_q == CH_W'(c)) sample_sel = pcm_rdata_id[c*PCM_W +: PCM_W];
    end
    samp_ext = P_W'(sample_sel);
    coef_ext = P_W'(win_rdata_id);
    prod_d   = byp_q ? (samp_ext <<< WIN_W) : (samp_ext * coef_ext);
    rnd      = (s2_prod_q + (P_W'(1) <<< (WIN_W - 1))) >>> WIN_W;
    result_d = PCM_W'(rnd);
  end

  // Control FSM: frame sequencing, read issue, busy/done/overrun.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state_q   <= IDLE;
      en_q      <= '0;
      byp_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_ch_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else if (abort_ih) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovr_q  <= pcm_rdy_ih && busy_q;
      case (state_q)
        IDLE: begin
          if (pcm_rdy_ih) begin
            if (first_found) begin
              state_q   <= LOAD;
              en_q      <= cfg_chnnl_en_id;
              byp_q     <= cfg_win_bypass_ih;
              rd_ch_q   <= first_ch;
              rd_addr_q <= '0;
              rd_en_q   <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (rd_addr_q == '1) begin
            rd_addr_q <= '0;
            if (next_found) begin
              rd_ch_q <= next_ch;
            end else begin
              rd_en_q <= 1'b0;
              state_q <= DRAIN;
            end
          end else begin
            rd_addr_q <= rd_addr_q + FFT_ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (!s1_v_q && !s2_v_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath pipeline: read-data stage, product stage, cache write stage.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      s1_v_q    <= 1'b0;
      s1_ch_q   <= '0;
      s1_rev_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_ch_q   <= '0;
      s2_rev_q  <= '0;
      s2_prod_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (abort_ih) begin
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      s1_v_q    <= rd_en_q;
      s1_ch_q   <= rd_ch_q;
      s1_rev_q  <= bitrev(rd_addr_q);
      s2_v_q    <= s1_v_q;
      s2_ch_q   <= s1_ch_q;
      s2_rev_q  <= s1_rev_q;
      s2_prod_q <= prod_d;
      wr_en_q   <= s2_v_q;
      if (s2_v_q) begin
        wr_addr_q <= {s2_ch_q, s2_rev_q};
        wr_data_q <= {{PCM_W{1'b0}}, result_d};
      end
    end
  end

  assign pcm_rd_en_oh     = rd_en_q;
  assign pcm_rd_addr_od   = rd_addr_q;
  assign win_rd_en_oh     = rd_en_q;
  assign win_rd_addr_od   = rd_addr_q;
  assign cache_wr_en_oh   = wr_en_q;
  assign cache_wr_addr_od = wr_addr_q;
  assign cache_wr_data_od = wr_data_q;
  assign busy_oh          = busy_q;
  assign done_oh          = done_q;
  assign overrun_oh       = ovr_q;

endmodule

// File: tb/tb_syn_fgyrus_pcm_loader.sv
// Directed bench for syn_fgyrus_pcm_loader with default parameters.
module tb_syn_fgyrus_pcm_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcm_rdy = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  cfg_en = 2'b11;
  logic        cfg_byp = 1'b0;
  logic        pcm_rd_en, win_rd_en, wr_en, busy, done, ovr;
  logic [6:0]  pcm_rd_addr, win_rd_addr;
  logic [31:0] pcm_rdata = '0;
  logic [15:0] win_rdata = '0;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  syn_fgyrus_pcm_loader #(.NUM_CHNNLS(2), .FFT_ADDR_W(7), .PCM_W(16), .WIN_W(16)) dut (
    .clk_ir(clk), .rst_il(rst_n), .pcm_rdy_ih(pcm_rdy), .abort_ih(abort),
    .cfg_chnnl_en_id(cfg_en), .cfg_win_bypass_ih(cfg_byp),
    .pcm_rd_en_oh(pcm_rd_en), .pcm_rd_addr_od(pcm_rd_addr), .pcm_rdata_id(pcm_rdata),
    .win_rd_en_oh(win_rd_en), .win_rd_addr_od(win_rd_addr), .win_rdata_id(win_rdata),
    .cache_wr_en_oh(wr_en), .cache_wr_addr_od(wr_addr), .cache_wr_data_od(wr_data),
    .busy_oh(busy), .done_oh(done), .overrun_oh(ovr));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] pcm_mem [2][128];
  logic [15:0] win_mem [128];

  // Synchronous-read RAM models, one cycle latency.
  always @(posedge clk) begin
    if (pcm_rd_en) begin
      pcm_rdata[15:0]  <= pcm_mem[0][pcm_rd_addr];
      pcm_rdata[31:16] <= pcm_mem[1][pcm_rd_addr];
    end
    if (win_rd_en) win_rdata <= win_mem[win_rd_addr];
  end

  logic [31:0] cache_mem [256];
  int wr_cnt = 0, done_cnt = 0, done_cyc = -1, ovr_cnt = 0, ovr_cyc = -1;
  int wr_cyc_log [4096];
  logic [7:0] wr_addr_log [4096];

  // Observe outputs mid-cycle and log every cache write.
  always @(negedge clk) begin
    if (wr_en) begin
      cache_mem[wr_addr]   <= wr_data;
      wr_cyc_log[wr_cnt]   <= cyc;
      wr_addr_log[wr_cnt]  <= wr_addr;
      wr_cnt               <= wr_cnt + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (ovr) begin
      ovr_cnt <= ovr_cnt + 1;
      ovr_cyc <= cyc;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] rev7(input logic [6:0] x);
    logic [6:0] r;
    for (int b = 0; b < 7; b++) r[b] = x[6-b];
    return r;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // pat 0: ch0 = 256*i, ch1 = -256*i; pat 1: signs swapped.
  task automatic fill(input int pat);
    for (int i = 0; i < 128; i++) begin
      pcm_mem[0][i] = 16'(pat == 0 ? 256 * i : -256 * i);
      pcm_mem[1][i] = 16'(pat == 0 ? -256 * i : 256 * i);
      win_mem[i]    = 16'h8000;
    end
  endtask

  task automatic check_cache(input string tag, input int pat, input logic [1:0] mask);
    int e;
    logic [7:0] a;
    for (int c = 0; c < 2; c++) begin
      if (mask[c]) begin
        for (int i = 0; i < 128; i++) begin
          e = ((c == 0) == (pat == 0)) ? 128 * i : -128 * i;
          a = {c[0], rev7(7'(i))};
          chk($sformatf("%s_ch%0d[%0d]", tag, c, i), 64'(cache_mem[a]), {32'h0, 16'h0, 16'(e)});
        end
      end
    end
  endtask

  task automatic start_load(input logic [1:0] mask, input logic byp, output int k);
    cfg_en  = mask;
    cfg_byp = byp;
    @(posedge clk);
    #1;
    k = cyc;
    pcm_rdy = 1'b1;
    @(posedge clk);
    #1;
    pcm_rdy = 1'b0;
  endtask

  // Full two-channel load with timing, count and content checks.
  task automatic full_load(input string tag, input int pat, input bit with_ovr);
    int k, w0, d0, o0;
    fill(pat);
    w0 = wr_cnt; d0 = done_cnt; o0 = ovr_cnt;
    start_load(2'b11, 1'b0, k);
    chk({tag, "_busy_start"}, 64'(busy), 64'd1);
    chk({tag, "_rd_en_start"}, 64'({pcm_rd_en, win_rd_en, pcm_rd_addr}), 64'h180);
    if (with_ovr) begin
      wait_cyc(k + 50);
      pcm_rdy = 1'b1;
      @(posedge clk);
      #1;
      pcm_rdy = 1'b0;
      chk({tag, "_ovr_pulse"}, 64'(ovr), 64'd1);
      @(posedge clk);
      #1;
      chk({tag, "_ovr_once"}, 64'(ovr), 64'd0);
    end
    wait_cyc(k + 259);
    chk({tag, "_busy_last"}, 64'({busy, done}), 64'b10);
    wait_cyc(k + 260);
    chk({tag, "_done_cyc"}, 64'({busy, done}), 64'b01);
    wait_cyc(k + 270);
    chk({tag, "_wr_cnt"}, 64'(wr_cnt - w0), 64'd256);
    chk({tag, "_first_wr"}, 64'(wr_cyc_log[w0] - k), 64'd4);
    chk({tag, "_last_wr"}, 64'(wr_cyc_log[w0 + 255] - k), 64'd259);
    chk({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_done_at"}, 64'(done_cyc - k), 64'd260);
    chk({tag, "_ovr_cnt"}, 64'(ovr_cnt - o0), with_ovr ? 64'd1 : 64'd0);
    if (with_ovr) chk({tag, "_ovr_at"}, 64'(ovr_cyc - k), 64'd51);
    check_cache(tag, pat, 2'b11);
  endtask

  initial begin
    int k, w0, d0, o0, lo;

    // Reset state
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({pcm_rd_en, pcm_rd_addr, win_rd_en, win_rd_addr, wr_en,
                              wr_addr, wr_data, busy, done, ovr}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", 64'(busy), 64'd0);

    // Default full load
    full_load("full0", 0, 1'b0);

    // Rounding through the window, channel 0 only
    for (int i = 0; i < 128; i++) begin
      pcm_mem[0][i] = '0; pcm_mem[1][i] = '0; win_mem[i] = 16'h8000;
    end
    pcm_mem[0][0] = 16'd3;
    pcm_mem[0][1] = 16'hFFFD;
    pcm_mem[0][2] = 16'h8000; win_mem[2] = 16'hFFFF;
    pcm_mem[0][3] = 16'h7FFF; win_mem[3] = 16'hFFFF;
    pcm_mem[0][4] = 16'hFFFD;
    w0 = wr_cnt; d0 = done_cnt;
    start_load(2'b01, 1'b0, k);
    wait_cyc(k + 140);
    chk("rnd_wr_cnt", 64'(wr_cnt - w0), 64'd128);
    chk("rnd_done_at", 64'(done_cyc - k), 64'd132);
    chk("rnd_p3", 64'(cache_mem[8'd0]), 64'h0000_0002);
    chk("rnd_m3", 64'(cache_mem[8'd64]), 64'h0000_FFFF);
    chk("rnd_min_ffff", 64'(cache_mem[8'd32]), 64'h0000_8001);
    chk("rnd_max_ffff", 64'(cache_mem[8'd96]), 64'h0000_7FFF);
    chk("rnd_m3_b", 64'(cache_mem[8'd16]), 64'h0000_FFFF);

    // Window bypass
    start_load(2'b01, 1'b1, k);
    wait_cyc(k + 140);
    chk("byp_p3", 64'(cache_mem[8'd0]), 64'h0000_0003);
    chk("byp_m3", 64'(cache_mem[8'd64]), 64'h0000_FFFD);
    chk("byp_min", 64'(cache_mem[8'd32]), 64'h0000_8000);
    chk("byp_m3_b", 64'(cache_mem[8'd16]), 64'h0000_FFFD);

    // Channel 0 masked
    fill(1);
    w0 = wr_cnt; d0 = done_cnt;
    start_load(2'b10, 1'b0, k);
    wait_cyc(k + 131);
    chk("m10_busy_last", 64'({busy, done}), 64'b10);
    wait_cyc(k + 140);
    chk("m10_wr_cnt", 64'(wr_cnt - w0), 64'd128);
    chk("m10_done_at", 64'(done_cyc - k), 64'd132);
    lo = 0;
    for (int j = w0; j < wr_cnt; j++) if (!wr_addr_log[j][7]) lo++;
    chk("m10_no_ch0", 64'(lo), 64'd0);
    check_cache("m10", 1, 2'b10);

    // No channel enabled
    w0 = wr_cnt; d0 = done_cnt;
    start_load(2'b00, 1'b0, k);
    chk("m00_done_pulse", 64'({busy, done}), 64'b01);
    wait_cyc(k + 10);
    chk("m00_wr_cnt", 64'(wr_cnt - w0), 64'd0);
    chk("m00_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Overrun during a load
    full_load("ovr", 0, 1'b1);

    // Abort at k+100 with a simultaneous pcm_rdy
    fill(0);
    w0 = wr_cnt; d0 = done_cnt; o0 = ovr_cnt;
    start_load(2'b11, 1'b0, k);
    wait_cyc(k + 100);
    abort = 1'b1;
    pcm_rdy = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    pcm_rdy = 1'b0;
    chk("abort_outputs", 64'({busy, wr_en, pcm_rd_en, done, ovr}), 64'd0);
    wait_cyc(k + 400);
    chk("abort_wr_cnt", 64'(wr_cnt - w0), 64'd97);
    chk("abort_last_wr", 64'(wr_cyc_log[wr_cnt - 1] - k), 64'd100);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_no_ovr", 64'(ovr_cnt - o0), 64'd0);
    full_load("post_abort", 1, 1'b0);

    // Asynchronous reset mid-load
    fill(1);
    start_load(2'b11, 1'b0, k);
    wait_cyc(k + 60);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 64'({pcm_rd_en, pcm_rd_addr, win_rd_en, win_rd_addr, wr_en,
                                wr_addr, wr_data, busy, done, ovr}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    w0 = wr_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_writes", 64'(wr_cnt - w0), 64'd0);
    chk("rst_idle", 64'({busy, pcm_rd_en}), 64'd0);
    full_load("post_rst", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
